nr_descrambler: RTL and testbench

NR_DESCRAMBLER -- requirements
Module: nr_descrambler

---
 rtl/nr_descrambler_pkg.sv | 45 ++++
 rtl/nr_descrambler_if.sv | 25 ++
 rtl/nr_descrambler_gold.sv | 36 +++
 rtl/nr_descrambler.sv | 116 +++++++++++
 tb/tb_nr_descrambler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/nr_descrambler_pkg.sv
// Shared Gold-sequence definitions for the NR scrambler/descrambler pair.
// Build option: NR_DESCRAMBLER_FAST_WARMUP_EN selects 8 LFSR steps per warm-up clock.
package nr_scrambler_pkg;

    // Gold sequence discard length before c(0)
    localparam int unsigned NC = 1600;
    // x1 seed: x1(0)=1, x1(1..30)=0
    localparam logic [30:0] X1_INIT = 31'h0000_0001;

`ifdef NR_DESCRAMBLER_FAST_WARMUP_EN
    localparam int unsigned WARM_STEPS = 8;
`else
    localparam int unsigned WARM_STEPS = 1;
`endif
    localparam int unsigned WARM_CYCLES = NC / WARM_STEPS;

    // FSM encoding kept as plain constants for compatibility with existing code
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WARMUP = 2'd1;
    localparam state_t ST_RUN    = 2'd2;

    // Bit i of each register holds x(n+i); bit 0 is the current sample
    typedef struct packed {
        logic [30:0] x1;
        logic [30:0] x2;
    } gold_t;

    function automatic gold_t gold_step1(input gold_t s);
        gold_t n;
        n.x1 = {s.x1[3] ^ s.x1[0], s.x1[30:1]};
        n.x2 = {s.x2[3] ^ s.x2[2] ^ s.x2[1] ^ s.x2[0], s.x2[30:1]};
        return n;
    endfunction

    function automatic gold_t gold_step8(input gold_t s);
        gold_t n;
        n = s;
        for (int unsigned i = 0; i < 8; i++) begin
            n = gold_step1(n);
        end
        return n;
    endfunction

endpackage

// File: rtl/nr_descrambler_if.sv
// LLR stream bundle (input and output valid/ready channels) for nr_descrambler.
// Build option: NR_DESCRAMBLER_FAST_WARMUP_EN does not affect this interface.
interface nr_descrambler_if #(
    parameter int LLR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [LLR_W-1:0] in_llr;
    logic             out_valid;
    logic             out_ready;
    logic [LLR_W-1:0] out_llr;
    logic             out_last;

    // Producer of scrambled LLRs / consumer of descrambled LLRs
    modport master (
        output in_valid, in_llr, out_ready,
        input  in_ready, out_valid, out_llr, out_last
    );

    // Descrambler side
    modport slave (
        input  in_valid, in_llr, out_ready,
        output in_ready, out_valid, out_llr, out_last
    );
endinterface

// File: rtl/nr_descrambler_gold.sv
// nr_gold_gen: x1/x2 LFSR pair with load, single step and warm-up step.
// Build option: NR_DESCRAMBLER_FAST_WARMUP_EN makes warm_step advance 8 steps.
module nr_gold_gen
    import nr_scrambler_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [30:0] c_init,
    input  logic        step,
    input  logic        warm_step,
    output logic        c
);

    gold_t st;

    // LFSR state: load has priority, then warm-up advance, then data step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= '0;
        end else if (load) begin
            st <= {X1_INIT, c_init};
        end else if (warm_step) begin
`ifdef NR_DESCRAMBLER_FAST_WARMUP_EN
            st <= gold_step8(st);
`else
            st <= gold_step1(st);
`endif
        end else if (step) begin
            st <= gold_step1(st);
        end
    end

    assign c = st.x1[0] ^ st.x2[0];

endmodule

// File: rtl/nr_descrambler.sv
// NR PDSCH/PUSCH LLR descrambler: Gold-sequence sign flip with saturation.
// Build option: NR_DESCRAMBLER_FAST_WARMUP_EN shortens warm-up to 200 clocks.
module nr_descrambler
    import nr_scrambler_pkg::*;
#(
    parameter int LLR_W = 8,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [30:0]       c_init,
    input  logic [LEN_W-1:0]  len,
    nr_descrambler_if.slave   strm,
    output logic              busy
);

    localparam logic [10:0] WARM_LAST = 11'(WARM_CYCLES - 1);
    localparam logic [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};
    localparam logic [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};

    state_t           state;
    logic [10:0]      wcnt;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             c;
    logic             load;
    logic             in_ready_w;
    logic             accept;
    logic             is_last;
    logic [LLR_W-1:0] descr;

    // A zero-length start aborts but never begins a codeword
    assign load       = start && (len != '0);
    assign in_ready_w = (state == ST_RUN) && (!strm.out_valid || strm.out_ready);
    assign accept     = in_ready_w && strm.in_valid;
    assign is_last    = (count == len_q - 1'b1);
    assign busy       = (state != ST_IDLE);

    assign strm.in_ready = in_ready_w;

    nr_gold_gen u_gold (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .c_init    (c_init),
        .step      (accept && !start),
        .warm_step ((state == ST_WARMUP) && !start),
        .c         (c)
    );

    // Sign flip where c(n)=1; the most negative code maps to the most positive
    always_comb begin
        descr = strm.in_llr;
        if (c) begin
            descr = (strm.in_llr == LLR_MIN) ? LLR_MAX : -strm.in_llr;
        end
    end

    // Control FSM: start reloads from any state, warm-up counter, output counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            count <= '0;
            len_q <= '0;
        end else if (start) begin
            state <= load ? ST_WARMUP : ST_IDLE;
            wcnt  <= '0;
            count <= '0;
            len_q <= len;
        end else begin
            case (state)
                ST_WARMUP: begin
                    if (wcnt == WARM_LAST) begin
                        state <= ST_RUN;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + 11'd1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (is_last) begin
                            state <= ST_IDLE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered output stage; holds while stalled, start discards pending data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            strm.out_llr   <= '0;
        end else if (start) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
        end else if (accept) begin
            strm.out_valid <= 1'b1;
            strm.out_last  <= is_last;
            strm.out_llr   <= descr;
        end else if (strm.out_ready) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nr_descrambler.sv
// Self-checking bench for nr_descrambler against an array-based Gold model.
// Build option: NR_DESCRAMBLER_FAST_WARMUP_EN changes expected warm-up latency.
module tb_nr_descrambler;

    localparam int LLR_W = 8;
    localparam int LEN_W = 16;
    localparam int NMAX  = 64;
    localparam int LMAX  = 127;
`ifdef NR_DESCRAMBLER_FAST_WARMUP_EN
    localparam int WARM = 201;
`else
    localparam int WARM = 1601;
`endif

    typedef struct {
        logic [LLR_W-1:0] llr;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [30:0]      c_init;
    logic [LEN_W-1:0] len;
    logic             busy;

    int checks = 0;
    int errors = 0;

    bit   x1 [0:1700];
    bit   x2 [0:1700];
    bit   c_ref [0:NMAX-1];
    exp_t exp_q [$];

    nr_descrambler_if #(.LLR_W(LLR_W)) bus ();

    nr_descrambler #(.LLR_W(LLR_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .c_init  (c_init),
        .len     (len),
        .strm    (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // c(n) straight from the sequence definition, one array entry per time index
    task automatic gen_model(input logic [30:0] ci, input int n);
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int m = 0; m + 31 <= 1600 + n - 1; m++) begin
            x1[m+31] = x1[m+3] ^ x1[m];
            x2[m+31] = x2[m+3] ^ x2[m+2] ^ x2[m+1] ^ x2[m];
        end
        for (int k = 0; k < n; k++) c_ref[k] = x1[k+1600] ^ x2[k+1600];
    endtask

    function automatic logic [LLR_W-1:0] model_llr(input logic [LLR_W-1:0] v, input bit cn);
        int vi;
        int e;
        vi = int'($signed(v));
        e  = cn ? -vi : vi;
        if (e > LMAX) e = LMAX;
        return LLR_W'(e);
    endfunction

    task automatic do_start(input logic [30:0] ci, input int l);
        @(negedge clk);
        c_init = ci;
        len    = LEN_W'(l);
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: constant +5; mode 1: random with forced -128/+127 extremes
    task automatic stream(input logic [30:0] ci, input int n_len, input bit rnd_rdy,
                          input bit rnd_val, input int mode, input int stop_at,
                          output int first_rdy);
        int n_in = 0;
        int n_out = 0;
        int cyc = 1;
        bit prev_acc = 0;
        bit prev_stall = 0;
        logic [31:0] held = '0;
        int r;
        exp_t e;
        first_rdy = -1;
        gen_model(ci, n_len);
        exp_q.delete();
        while (n_out < n_len && (stop_at == 0 || n_out < stop_at) && cyc < 4000) begin
            @(negedge clk);
            bus.out_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
            bus.in_valid  = (n_in < n_len) && (rnd_val ? 1'($urandom_range(1, 0)) : 1'b1);
            r = $urandom_range(3, 0);
            if (mode == 0)   bus.in_llr = 8'd5;
            else if (r == 0) bus.in_llr = 8'h80;
            else if (r == 1) bus.in_llr = 8'h7F;
            else             bus.in_llr = 8'($urandom);
            #1;
            if (cyc == 1) chk("busy_warm", 32'(busy), 32'd1);
            if (first_rdy < 0 && bus.in_ready) first_rdy = cyc;
            if (prev_acc) chk("latency", 32'(bus.out_valid), 32'd1);
            if (prev_stall) chk("hold", {23'b0, bus.out_last, bus.out_llr}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("llr", 32'(bus.out_llr), 32'(e.llr));
                    chk("last", 32'(bus.out_last), 32'(e.last));
                end
                n_out++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = {23'b0, bus.out_last, bus.out_llr};
            prev_acc   = bus.in_valid && bus.in_ready;
            if (prev_acc) begin
                e.llr  = model_llr(bus.in_llr, c_ref[n_in]);
                e.last = (n_in == n_len - 1);
                exp_q.push_back(e);
                n_in++;
            end
            @(posedge clk);
            cyc++;
        end
        #1 bus.in_valid = 1'b0;
        if (cyc >= 4000) chk("timeout", 32'(n_out), 32'(n_len));
        if (stop_at == 0) begin
            chk("idle_after", 32'(busy), 32'd0);
            chk("q_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr;
        logic [30:0] ci_a;
        logic [30:0] ci_b;
        ci_a = 31'(32'h12345678 & 32'h7FFFFFFF);
        ci_b = 31'h0ACE_1357;
        reset_n = 1'b0;
        start = 1'b0;
        c_init = '0;
        len = '0;
        bus.in_valid = 1'b0;
        bus.in_llr = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_out_llr", 32'(bus.out_llr), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Golden codeword, constant +5, no back-pressure; also warm-up latency
        do_start(ci_a, 64);
        stream(ci_a, 64, 0, 0, 0, 0, fr);
        chk("warm_lat", 32'(fr), 32'(WARM));

        // Saturation corners mixed into random LLRs
        do_start(ci_a, 64);
        stream(ci_a, 64, 0, 0, 1, 0, fr);

        // Random back-pressure and input gaps on the golden codeword
        do_start(ci_a, 64);
        stream(ci_a, 64, 1, 1, 0, 0, fr);

        // Restart after 10 outputs with a new seed
        do_start(ci_a, 64);
        stream(ci_a, 64, 0, 0, 1, 10, fr);
        do_start(ci_b, 40);
        chk("abort_drop", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        stream(ci_b, 40, 1, 0, 1, 0, fr);

        // Asynchronous reset after 20 outputs
        do_start(ci_b, 64);
        stream(ci_b, 64, 0, 0, 0, 20, fr);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_last", 32'(bus.out_last), 32'd0);
        chk("arst_out_llr", 32'(bus.out_llr), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        do_start(31'h0000_0001, 1);
        stream(31'h0000_0001, 1, 0, 0, 1, 0, fr);

        // Zero-length start is ignored, and IDLE ignores in_valid
        do_start(ci_a, 0);
        chk("len0_busy", 32'(busy), 32'd0);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
